wave_ram_arbiter: RTL
=====================

# wave_ram_arbiter

Shares the single-port waveform RAM (triangle/sine/square tables, 3072 × 32) between NUM_CH DDS read channels and one table-loader write port. Reads are arbitrated round-robin; writes have priority, optionally capped by a burst limit so DDS channels keep streaming during table reloads. The block sits between the DDS phase accumulators and the RAM instance and owns the RAM's address, data and write-enable lines.

## Interface
- NUM_CH, 4, number of read requesters (2..8)
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 12, RAM address width
- DATA_DEPTH, 3072, valid words; addresses ≥ DATA_DEPTH are out of range
- RD_LAT, 1, RAM read latency in cycles (address register to ram_dout)
- WR_BURST_MAX, 8, max consecutive write grants while reads are pending

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_req  in  NUM_CH  per-channel read request, held until granted
- rd_addr  in  NUM_CH*ADDR_WIDTH  per-channel address, channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_gnt  out  NUM_CH  one-hot, combinational, read accepted this cycle
- rd_valid  out  NUM_CH  one-hot, rd_data belongs to this channel
- rd_data  out  DATA_WIDTH  shared read return bus
- wr_req, wr_addr (ADDR_WIDTH), wr_data (DATA_WIDTH)  in  loader write request
- wr_gnt  out  1  combinational, write accepted this cycle
- ram_we  out  1  to RAM wrn: 1 = write, 0 = read
- ram_addr  out  ADDR_WIDTH;  ram_din  out  DATA_WIDTH;  ram_dout  in  DATA_WIDTH
- addr_err  out  1  sticky, out-of-range access seen

## Operation
- One access per cycle maximum; in each cycle at most one of wr_gnt / rd_gnt bits is high.
- Priority: write wins unless the burst limit applies (see Configuration); otherwise the read winner is picked round-robin starting at last_ch+1 mod NUM_CH.
- last_ch updates only on a read grant; reset value NUM_CH-1 (channel 0 wins first).
- Grant cycle t: rd_gnt/wr_gnt high combinationally; ram_we/ram_addr/ram_din registered at the end of t.
- Requester advances (new address or drops req) at the edge where it saw gnt; keeping req high requests another access and competes again.
- Read-return pipeline: shift register of {valid, channel} of depth RD_LAT+1; rd_data registered from ram_dout; rd_valid[ch] and rd_data appear together.
- Out-of-range address (≥ DATA_DEPTH): request still granted; write suppressed (ram_we stays 0, ram_addr 0); read returns rd_data = 0 with rd_valid asserted; addr_err set, cleared only by reset.
- Idle cycle (no grant): ram_we = 0, ram_addr/ram_din hold previous value.

## Timing
- Reset values: rd_valid 0, rd_data 0, ram_we 0, ram_addr 0, ram_din 0, addr_err 0, burst counter 0, pipeline empty; rd_gnt/wr_gnt 0 while rst_n low.
- Read latency: grant in cycle t → rd_valid in cycle t+RD_LAT+2 (t+3 at default); throughput one read per cycle.
- Write: grant in cycle t → RAM write at edge ending t+1.
- Write then read of the same address in consecutive grants returns the new data.
- Reset mid-operation: in-flight reads discarded, no rd_valid after reset release for pre-reset grants.
- Simultaneous wr_req and all rd_req: see Configuration; round-robin order unaffected by write grants.

## Configuration
- Macro WAVE_ARB_BURST_LIMIT_EN.
- Defined: counter of consecutive write grants; when it reaches WR_BURST_MAX and any rd_req is high, the next cycle grants a read (round-robin) instead of the write; counter clears on any cycle without a write grant.
- Undefined: writes strictly preempt reads; reads starve while wr_req stays high; counter not built.

## Test plan
- Reset: assert rst_n low mid-stream with 2 reads in flight -> all outputs 0, no rd_valid after release.
- Single read ch2, rd_addr=0x405, RAM preloaded 0x405=0xDEADBEEF -> rd_gnt=0b0100 cycle t, rd_valid=0b0100, rd_data=0xDEADBEEF at t+3.
- All 4 rd_req held 8 cycles -> grants ch0,1,2,3,0,1,2,3; returns in same order, 3-cycle lag.
- wr_req held 20 cycles plus rd_req[1] held, macro defined, WR_BURST_MAX=8 -> 8 writes, 1 read ch1, repeat; macro undefined -> 20 writes, then ch1 read.
- Write 0x123 = 0xA5A5A5A5 then read 0x123 next cycle -> rd_data=0xA5A5A5A5.
- Read addr 0xC00 (3072) and write addr 0xFFF -> both granted, ram_we never 1, rd_data=0, addr_err=1 until reset.

Source files
------------

// File: rtl/wave_ram_arbiter.sv
// wave_ram_arbiter: shares the single-port waveform RAM between NUM_CH DDS
// readers (round-robin) and one table loader (priority). Option: WAVE_ARB_BURST_LIMIT_EN.
module wave_ram_arbiter #(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned DATA_DEPTH   = 3072,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned WR_BURST_MAX = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_CH-1:0]            rd_req,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_CH-1:0]            rd_gnt,
   output logic [NUM_CH-1:0]            rd_valid,
   output logic [DATA_WIDTH-1:0]        rd_data,
   input  logic                         wr_req,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic                         wr_gnt,
   output logic                         ram_we,
   output logic [ADDR_WIDTH-1:0]        ram_addr,
   output logic [DATA_WIDTH-1:0]        ram_din,
   input  logic [DATA_WIDTH-1:0]        ram_dout,
   output logic                         addr_err
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PIPE = RD_LAT + 1;

   logic [CH_W-1:0]           last_ch_q, last_ch_d;
   logic [CH_W-1:0]           rr_ch;
   logic                      any_rd;
   logic                      burst_hold;
   logic                      wr_win;
   logic                      rd_win;
   logic [ADDR_WIDTH-1:0]     sel_addr;
   logic                      wr_ok;
   logic                      rd_ok;

   logic                      ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0]     ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0]     ram_din_q, ram_din_d;
   logic                      addr_err_q, addr_err_d;

   logic [PIPE-1:0]           pv_q, pv_d;
   logic [PIPE-1:0][CH_W-1:0] pc_q, pc_d;
   logic [PIPE-1:0]           po_q, po_d;
   logic [NUM_CH-1:0]         rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0]     rd_data_q, rd_data_d;

   // round-robin search starting one past the last granted channel
   always_comb begin
      logic [CH_W:0] idx;
      logic          found;
      found = 1'b0;
      rr_ch = '0;
      idx   = '0;
      for (int unsigned off = 1; off <= NUM_CH; off++) begin
         idx = {1'b0, last_ch_q} + (CH_W+1)'(off);
         if (idx >= (CH_W+1)'(NUM_CH)) begin
            idx = idx - (CH_W+1)'(NUM_CH);
         end
         if (!found && rd_req[idx[CH_W-1:0]]) begin
            found = 1'b1;
            rr_ch = idx[CH_W-1:0];
         end
      end
   end

   assign any_rd   = |rd_req;
   assign sel_addr = rd_addr[rr_ch*ADDR_WIDTH +: ADDR_WIDTH];
   assign wr_ok    = {1'b0, wr_addr}  < (ADDR_WIDTH+1)'(DATA_DEPTH);
   assign rd_ok    = {1'b0, sel_addr} < (ADDR_WIDTH+1)'(DATA_DEPTH);

   // grants are forced low while reset is held
   assign wr_win = rst_n & wr_req & ~burst_hold;
   assign rd_win = rst_n & any_rd & ~wr_win;
   assign wr_gnt = wr_win;
   assign rd_gnt = rd_win ? (NUM_CH'(1) << rr_ch) : '0;

`ifdef WAVE_ARB_BURST_LIMIT_EN
   localparam int unsigned BW = $clog2(WR_BURST_MAX + 1);

   logic [BW-1:0] burst_q, burst_d;

   assign burst_hold = (burst_q == BW'(WR_BURST_MAX)) & any_rd;

   // count consecutive write grants, saturating at the cap
   always_comb begin
      burst_d = '0;
      if (wr_win) begin
         if (burst_q == BW'(WR_BURST_MAX)) begin
            burst_d = burst_q;
         end else begin
            burst_d = burst_q + BW'(1);
         end
      end
   end

   // burst counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end
`else
   // no burst cap in this build: writes always win
   assign burst_hold = 1'b0 & (WR_BURST_MAX != 0);
`endif

   // RAM control, round-robin pointer and sticky range error
   always_comb begin
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      addr_err_d = addr_err_q;
      last_ch_d  = last_ch_q;
      if (wr_win) begin
         ram_we_d   = wr_ok;
         ram_addr_d = wr_ok ? wr_addr : '0;
         if (wr_ok) begin
            ram_din_d = wr_data;
         end else begin
            addr_err_d = 1'b1;
         end
      end else if (rd_win) begin
         ram_addr_d = rd_ok ? sel_addr : '0;
         last_ch_d  = rr_ch;
         if (!rd_ok) begin
            addr_err_d = 1'b1;
         end
      end
   end

   // read-return tracking: {valid, channel, out-of-range} per RAM stage
   always_comb begin
      pv_d    = pv_q;
      pc_d    = pc_q;
      po_d    = po_q;
      pv_d[0] = rd_win;
      pc_d[0] = rr_ch;
      po_d[0] = rd_win & ~rd_ok;
      for (int i = 1; i < int'(PIPE); i++) begin
         pv_d[i] = pv_q[i-1];
         pc_d[i] = pc_q[i-1];
         po_d[i] = po_q[i-1];
      end
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
      if (pv_q[PIPE-1]) begin
         rd_valid_d = NUM_CH'(1) << pc_q[PIPE-1];
         rd_data_d  = po_q[PIPE-1] ? '0 : ram_dout;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_ch_q  <= CH_W'(NUM_CH - 1);
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         addr_err_q <= 1'b0;
         pv_q       <= '0;
         pc_q       <= '0;
         po_q       <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         last_ch_q  <= last_ch_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         addr_err_q <= addr_err_d;
         pv_q       <= pv_d;
         pc_q       <= pc_d;
         po_q       <= po_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign addr_err = addr_err_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule
